// File: rtl/dsm_decimator_if.sv
// Sample-path bundle between a 1-bit delta-sigma source and the sinc3 decimator.
// The decimator uses the slave modport; the bitstream source uses the master modport.
interface dsm_decimator_if #(
   parameter int LOG2_OSR = 6
);
   localparam int DOUT_W = 2 + 3 * LOG2_OSR;

   logic              pwm_in;
   logic [DOUT_W-1:0] dout;
   logic              dout_valid;

   modport master (
      output pwm_in,
      input  dout,
      input  dout_valid
   );

   modport slave (
      input  pwm_in,
      output dout,
      output dout_valid
   );
endinterface

// File: rtl/dsm_decimator.sv
// Third-order CIC (sinc3) decimator: 1-bit delta-sigma stream in, one DOUT_W-bit sample per 2^LOG2_OSR bits.
// Define DSM_DEC_SETTLE_EN to hide the first three start-up samples from dout_valid.
module dsm_decimator #(
   parameter int LOG2_OSR = 6
) (
   input  logic           clock,
   input  logic           reset,
   dsm_decimator_if.slave dif
);
   localparam int DOUT_W = 2 + 3 * LOG2_OSR;

   function automatic logic signed [DOUT_W-1:0] map_bit(input logic b);
      return b ? {{(DOUT_W-1){1'b0}}, 1'b1} : {DOUT_W{1'b1}};
   endfunction

   logic [LOG2_OSR-1:0]      cnt;
   logic                     dec_p0;
   logic signed [DOUT_W-1:0] i1_p0;
   logic signed [DOUT_W-1:0] i2_p0;
   logic signed [DOUT_W-1:0] i3_p0;
   logic signed [DOUT_W-1:0] d1_p1;
   logic signed [DOUT_W-1:0] d2_p1;
   logic signed [DOUT_W-1:0] d3_p1;
   logic signed [DOUT_W-1:0] c1_p1;
   logic signed [DOUT_W-1:0] c2_p1;
   logic signed [DOUT_W-1:0] c3_p1;
   logic signed [DOUT_W-1:0] dout_p2;
   logic                     vld_p2;
   logic                     show;

   assign dec_p0 = (cnt == {LOG2_OSR{1'b1}});

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + LOG2_OSR'(1);
      end
   end

   // Stage p0: integrators at the input rate; modulo wrap is what makes the CIC exact.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         i1_p0 <= '0;
         i2_p0 <= '0;
         i3_p0 <= '0;
      end else begin
         i1_p0 <= i1_p0 + map_bit(dif.pwm_in);
         i2_p0 <= i2_p0 + i1_p0;
         i3_p0 <= i3_p0 + i2_p0;
      end
   end

   // Stage p1: comb section, only advanced at a decimation event.
   always_comb begin
      c1_p1 = i3_p0 - d1_p1;
      c2_p1 = c1_p1 - d2_p1;
      c3_p1 = c2_p1 - d3_p1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         d1_p1 <= '0;
         d2_p1 <= '0;
         d3_p1 <= '0;
      end else if (dec_p0) begin
         d1_p1 <= i3_p0;
         d2_p1 <= c1_p1;
         d3_p1 <= c2_p1;
      end
   end

`ifdef DSM_DEC_SETTLE_EN
   logic [1:0] settle;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         settle <= '0;
      end else if (dec_p0 && (settle != 2'd3)) begin
         settle <= settle + 2'd1;
      end
   end

   assign show = (settle == 2'd3);
`else
   assign show = 1'b1;
`endif

   // Stage p2: output hold register and strobe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dout_p2 <= '0;
         vld_p2  <= 1'b0;
      end else begin
         vld_p2 <= dec_p0 && show;
         if (dec_p0) begin
            dout_p2 <= c3_p1;
         end
      end
   end

   assign dif.dout       = dout_p2;
   assign dif.dout_valid = vld_p2;
endmodule

// File: tb/tb_dsm_decimator.sv
// Bench for dsm_decimator: table-driven patterns plus step, loopback and reset sequences,
// each strobe compared against a direct sinc3 convolution of the recorded input bits.
module tb_dsm_decimator;
   localparam int LOG2_OSR = 6;
   localparam int OSR      = 64;
   localparam int DOUT_W   = 20;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   dsm_decimator_if #(.LOG2_OSR(LOG2_OSR)) dif ();

   dsm_decimator #(.LOG2_OSR(LOG2_OSR)) dut (
      .clock (clock),
      .reset (reset),
      .dif   (dif)
   );

   typedef struct {
      string name;
      int    pattern;
      int    nedges;
      bit    chk_const;
      int    steady;
   } vec_t;

   vec_t              tbl [5];
   bit                xs [$];
   logic [DOUT_W-1:0] got [$];
   int                nedge;
   int                nstrobe;
   logic [DOUT_W-1:0] exp_dout;
   int                nchecks = 0;
   int                nerrors = 0;

   task automatic check(input string name, input longint act, input longint exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, nedge, act, exp);
      end
   endtask

   task automatic check_true(input string name, input bit ok, input longint a, input longint b);
      nchecks++;
      if (!ok) begin
         nerrors++;
         $display("FAIL %s at edge %0d: value %0d against %0d", name, nedge, a, b);
      end
   endtask

   function automatic longint wt(input longint t);
      return (t < 2) ? 0 : (t * (t - 1)) / 2;
   endfunction

   // Output of strobe k: input bits convolved with the sinc3 impulse response, taken mod 2^DOUT_W.
   function automatic logic [DOUT_W-1:0] model_out(input int k);
      longint acc = 0;
      longint h;
      int lo = (OSR * k - 193 < 0) ? 0 : OSR * k - 193;
      for (int j = lo; j <= OSR * k - 4; j++) begin
         if (j < xs.size()) begin
            h = wt(OSR * k - 2 - j) - 3 * wt(OSR * (k - 1) - 2 - j)
              + 3 * wt(OSR * (k - 2) - 2 - j) - wt(OSR * (k - 3) - 2 - j);
            acc += xs[j] ? h : -h;
         end
      end
      return acc[DOUT_W-1:0];
   endfunction

   function automatic int sx(input logic [DOUT_W-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic int exp_strobes(input int n);
`ifdef DSM_DEC_SETTLE_EN
      return (n / OSR > 3) ? n / OSR - 3 : 0;
`else
      return n / OSR;
`endif
   endfunction

   function automatic bit pat_bit(input int pattern, input int n);
      case (pattern)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return (n % 2) == 0;
         3:       return 1'($urandom_range(0, 1));
         default: return n >= 512;
      endcase
   endfunction

   task automatic step(input bit b);
      bit ev;
      bit exp_v;
      dif.pwm_in = b;
      xs.push_back(b);
      @(posedge clock);
      #1;
      nedge++;
      ev = (nedge % OSR) == 0;
`ifdef DSM_DEC_SETTLE_EN
      exp_v = ev && (nedge >= 4 * OSR);
`else
      exp_v = ev;
`endif
      if (ev) begin
         exp_dout = model_out(nedge / OSR);
         got.push_back(dif.dout);
      end
      if (dif.dout_valid) nstrobe++;
      check("dout_valid", longint'(dif.dout_valid), longint'(exp_v));
      check("dout", longint'(dif.dout), longint'(exp_dout));
      @(negedge clock);
   endtask

   // Reset is raised mid-cycle so the clear must be asynchronous; held 20 ns.
   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      check("reset_dout", longint'(dif.dout), 0);
      check("reset_valid", longint'(dif.dout_valid), 0);
      #19;
      reset    = 1'b0;
      xs.delete();
      got.delete();
      nedge    = 0;
      nstrobe  = 0;
      exp_dout = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DOUT_W-1:0] s20;
      int acc;
      int lvl;
      longint sum;
      longint mean;
      longint target;
      int levels [3];

      dif.pwm_in = 1'b0;
      nedge      = 0;
      nstrobe    = 0;
      exp_dout   = '0;

      tbl[0] = '{"ones",   0, 1024, 1'b1,  262144};
      tbl[1] = '{"zeros",  1, 1024, 1'b1, -262144};
      tbl[2] = '{"alt",    2, 1024, 1'b1,  0};
      tbl[3] = '{"random", 3, 1024, 1'b0,  0};
      tbl[4] = '{"step",   4, 1024, 1'b0,  0};

      for (int i = 0; i < 5; i++) begin
         do_reset();
         for (int n = 0; n < tbl[i].nedges; n++) step(pat_bit(tbl[i].pattern, n));
         check({tbl[i].name, "_strobes"}, nstrobe, exp_strobes(nedge));
         if (tbl[i].chk_const) begin
            s20 = DOUT_W'(tbl[i].steady);
            for (int k = 3; k < got.size(); k++) check({tbl[i].name, "_steady"}, longint'(got[k]), longint'(s20));
         end
      end

      // Step from zeros to ones: strobe 8 is full negative, then a monotonic climb to full positive.
      do_reset();
      for (int n = 0; n < 1280; n++) step(pat_bit(4, n));
      check("step_low", longint'(got[7]), longint'(20'hC0000));
      for (int k = 8; k <= 11; k++)
         check_true("step_mono", sx(got[k]) >= sx(got[k-1]), sx(got[k]), sx(got[k-1]));
      check("step_high", longint'(got[11]), longint'(20'h40000));
      check("step_strobes", nstrobe, exp_strobes(nedge));

      // Loopback through a first-order delta-sigma model of dsm at 25/50/75 % of range.
      levels = '{64, 128, 192};
      for (int l = 0; l < 3; l++) begin
         do_reset();
         lvl = levels[l];
         acc = int'($urandom_range(0, 255));
         for (int n = 0; n < 64 * OSR; n++) begin
            acc += lvl;
            if (acc >= 256) begin
               acc -= 256;
               step(1'b1);
            end else begin
               step(1'b0);
            end
         end
         sum = 0;
         for (int k = 3; k < 64; k++) sum += sx(got[k]);
         mean   = sum / 61;
         target = (longint'(2 * lvl - 256) * 262144) / 256;
         check_true("loopback_mean", (mean - target <= 2621) && (target - mean <= 2621), mean, target);
      end

      // Mid-stream reset with random input, then the first strobe must land 64 edges after release.
      for (int n = 0; n < 100; n++) step(1'($urandom_range(0, 1)));
      do_reset();
      for (int n = 0; n < 5 * OSR; n++) step(1'($urandom_range(0, 1)));
      check("rst_resume_strobes", nstrobe, exp_strobes(nedge));

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end
endmodule

// File: doc/dsm_decimator.md
# dsm_decimator

Receive-side counterpart of the delta-sigma modulator: takes the 1-bit `pwm` bitstream and reconstructs a 20-bit sample stream. It uses a third-order CIC (sinc3) decimation filter at a power-of-two oversampling ratio. It sits downstream of `dsm` in loopback benches and in the ADC-style receive path, with one output strobe per OSR input bits.

## Interface
- `LOG2_OSR`, default 6: log2 of the decimation ratio, so OSR = 2^LOG2_OSR = 64. The filter is only specified for the default value.
- `DOUT_W`, derived as 2 + 3*LOG2_OSR (20 at default): internal register and output width. It is a localparam and cannot be overridden.
- `clock`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high. Clears all state immediately.
- `pwm_in`  in  1: modulator bitstream, sampled on every rising edge.
- `dout`  out  DOUT_W: decimated sample, two's complement, held between strobes.
- `dout_valid`  out  1: one-cycle strobe marking a new `dout`.

## Operation
- Input mapping: `pwm_in`=1 maps to +1 and `pwm_in`=0 maps to -1, sign-extended to DOUT_W bits.
- Integrators I1, I2, I3 (DOUT_W bits, registered) update every edge, each from the old value of its upstream stage:
  - I1 <= I1 + x
  - I2 <= I2 + I1
  - I3 <= I3 + I2
- All arithmetic wraps modulo 2^DOUT_W. There is no saturation anywhere; CIC correctness relies on this wrap.
- Phase counter `cnt` (LOG2_OSR bits):
  - Increments every edge and wraps from OSR-1 to 0.
  - A decimation event is an edge at which `cnt`==OSR-1.
- Comb section, evaluated only at a decimation event and using the current (pre-edge) I3:
  - C1 = I3 - D1
  - C2 = C1 - D2
  - C3 = C2 - D3
  - Delays update as D1<=I3, D2<=C1, D3<=C2.
  - All comb arithmetic wraps at DOUT_W.
- `dout` <= C3 at each decimation event and holds otherwise.
- Steady-state gain is OSR^3 = 2^18:
  - Constant ones: `dout` = +262144 (0x40000).
  - Constant zeros: `dout` = -262144 (0xC0000).
  - Alternating 1/0: `dout` = 0.
- Reset, asserted at any time including mid-frame:
  - Clears to 0: I1..I3, D1..D3, `cnt`, the settle counter, `dout` and `dout_valid`.
  - No strobe is produced until a full OSR edges have elapsed after release.

## Timing
- Reset values: `dout`=0, `dout_valid`=0.
- First strobe after reset release:
  - `dout_valid` is high in the cycle following the 64th rising edge after release.
  - Strobes then repeat every 64 cycles, exactly one cycle wide, never back-to-back.
- `dout` and `dout_valid` change on the same edge. `dout` is stable for 64 cycles after each strobe.
- Latency:
  - Integrator pipeline adds 3 cycles from input to I3.
  - The impulse response spans 3*OSR-2 = 190 input bits.
  - For an input held constant from reset release, the 4th strobe and every later strobe carry the exact steady-state value.
- `pwm_in` is assumed synchronous to `clock`. No internal synchroniser is provided.

## Configuration
- `DSM_DEC_SETTLE_EN` defined:
  - A 2-bit settle counter suppresses `dout_valid` for the first 3 decimation events after reset.
  - `dout` still updates internally at those events.
  - The first visible strobe occurs in the cycle after the 256th edge.
  - The counter saturates at 3 and clears only on reset.
- `DSM_DEC_SETTLE_EN` undefined:
  - No settle counter.
  - `dout_valid` fires on every decimation event, starting with the first after 64 edges.
  - The first 3 samples carry filter start-up transients.

## Test plan
- Reset check: assert `reset` for 20 ns mid-stream with `pwm_in` toggling.
  - Required response: `dout`=0 and `dout_valid`=0 immediately, without waiting for a clock edge.
  - The next strobe occurs exactly 64 edges after release.
- All-ones: `pwm_in`=1 held from reset release.
  - Required response: strobes every 64 cycles.
  - The 4th and all later strobes give `dout`=262144.
  - With the macro defined, no strobe occurs before the 256th edge.
- All-zeros: `pwm_in`=0 held.
  - Required response: the 4th strobe onward gives `dout`=-262144 (0xC0000).
  - This checks two's-complement wrap in the integrators.
- Alternating 1/0 for 1024 edges.
  - Required response: the 4th strobe onward gives `dout`=0 exactly.
- Loopback: `dsm` driven with constant `vin`, its `pwm` fed to `pwm_in`, run for 64 strobes.
  - Required response: the mean `dout` tracks `vin` scaled by the `dsm` transfer.
  - Error is within ±1% of full scale for `vin` at 25%, 50% and 75% of range.
- Step: all-zeros for 512 edges, then all-ones.
  - Required response: `dout` rises monotonically over 3 strobes from -262144 to +262144.
  - No strobe is skipped or doubled across the step.
